// File: rtl/cmac_lbus_pkg.sv
// Shared LBUS types, widths and tkeep helpers for the CMAC TX adapter.
package cmac_lbus_pkg;
  localparam int SEG_W     = 128;
  localparam int SEG_BYTES = 16;
  localparam int MTY_W     = 4;
  localparam int AXIS_W    = 512;
  localparam int KEEP_W    = AXIS_W / 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } tx_state_e;

  typedef struct packed {
    logic [SEG_W-1:0] data;
    logic             ena;
    logic             sop;
    logic             eop;
    logic             err;
    logic [MTY_W-1:0] mty;
  } lbus_seg_t;

  // Empty-byte count of one segment; an all-zero keep reports 15 (one junk byte sent).
  function automatic logic [MTY_W-1:0] keep_to_mty(input logic [SEG_BYTES-1:0] keep);
    logic [MTY_W:0] pc;
    pc = '0;
    for (int i = 0; i < SEG_BYTES; i++) pc = pc + {{MTY_W{1'b0}}, keep[i]};
    if (pc == '0) return MTY_W'(SEG_BYTES - 1);
    return MTY_W'((MTY_W+1)'(SEG_BYTES) - pc);
  endfunction

  // True when the set bits of keep form one run starting at bit 0 (zero keep counts as contiguous).
  function automatic logic keep_contig(input logic [KEEP_W-1:0] keep);
    return ((keep & (keep + KEEP_W'(1))) == '0);
  endfunction
endpackage

// File: rtl/cmac_lbus_tx_adapter_if.sv
// 512-bit AXI4-Stream bundle feeding the LBUS TX adapter.
interface cmac_lbus_tx_adapter_if;
  import cmac_lbus_pkg::*;
  logic [AXIS_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/cmac_lbus_seg_map.sv
// One LBUS segment: byte-reverse AXIS bytes into LBUS order, derive enable and empty count.
module cmac_lbus_seg_map
  import cmac_lbus_pkg::*;
(
  input  logic [SEG_W-1:0]     seg_data_i,
  input  logic [SEG_BYTES-1:0] seg_keep_i,
  output logic [SEG_W-1:0]     lbus_data_o,
  output logic                 ena_o,
  output logic [MTY_W-1:0]     mty_o
);
  // Segment byte 0 goes to the top byte lane of the LBUS word.
  always_comb begin
    lbus_data_o = '0;
    for (int j = 0; j < SEG_BYTES; j++) lbus_data_o[SEG_W-1-8*j -: 8] = seg_data_i[8*j +: 8];
  end

  assign ena_o = |seg_keep_i;
  assign mty_o = keep_to_mty(seg_keep_i);
endmodule

// File: rtl/cmac_lbus_tx_adapter.sv
// AXIS 512b -> CMAC TX LBUS (4 x 128b) with one registered stage, packet framing and error tagging.
module cmac_lbus_tx_adapter
  import cmac_lbus_pkg::*;
#(
  parameter int SEG_CNT = 4,
  parameter int CNT_W   = 32
) (
  input  logic                 cmac_tx_clk,
  input  logic                 cmac_rst,
  input  logic                 tx_enable,
  cmac_lbus_tx_adapter_if.slave s_axis,
  input  logic                 tx_rdyout,
  input  logic                 tx_ovfout,
  input  logic                 tx_unfout,
  output logic [SEG_W-1:0]     tx_datain0, tx_datain1, tx_datain2, tx_datain3,
  output logic                 tx_enain0, tx_enain1, tx_enain2, tx_enain3,
  output logic                 tx_sopin0, tx_sopin1, tx_sopin2, tx_sopin3,
  output logic                 tx_eopin0, tx_eopin1, tx_eopin2, tx_eopin3,
  output logic                 tx_errin0, tx_errin1, tx_errin2, tx_errin3,
  output logic [MTY_W-1:0]     tx_mtyin0, tx_mtyin1, tx_mtyin2, tx_mtyin3,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 ovf_sticky,
  output logic                 unf_sticky
);
  localparam int SEL_W = $clog2(SEG_CNT);

  tx_state_e          state_q, state_d;
  logic               rdy_q, pkt_err_q, ovf_q, unf_q;
  logic [CNT_W-1:0]   pkt_cnt_q, err_cnt_q;
  lbus_seg_t          seg_q [SEG_CNT];
  lbus_seg_t          seg_d [SEG_CNT];
  logic               tready, accept, beat_err, zero_last;
  logic [SEG_W-1:0]   map_data [SEG_CNT];
  logic [MTY_W-1:0]   map_mty  [SEG_CNT];
  logic [SEG_CNT-1:0] map_ena, ena_eff;
  logic [SEL_W-1:0]   eop_seg;

  for (genvar g = 0; g < SEG_CNT; g++) begin : g_seg
    cmac_lbus_seg_map u_seg_map (
      .seg_data_i (s_axis.tdata[g*SEG_W +: SEG_W]),
      .seg_keep_i (s_axis.tkeep[g*SEG_BYTES +: SEG_BYTES]),
      .lbus_data_o(map_data[g]),
      .ena_o      (map_ena[g]),
      .mty_o      (map_mty[g])
    );
  end

  // New packets wait for tx_enable; an open packet only waits for CMAC ready.
  assign tready        = rdy_q & (tx_enable | (state_q == ST_IN_PKT));
  assign accept        = s_axis.tvalid & tready;
  assign s_axis.tready = tready;

  // Next packet state from accepted beats.
  always_comb begin
    state_d = state_q;
    if (accept) state_d = s_axis.tlast ? ST_IDLE : ST_IN_PKT;
  end

  // Build the four LBUS segments of the current beat; fields stay zero on disabled segments.
  always_comb begin
    zero_last = s_axis.tlast && (s_axis.tkeep == '0);
    beat_err  = !keep_contig(s_axis.tkeep) || (!s_axis.tlast && (s_axis.tkeep != '1)) || zero_last;
    ena_eff   = map_ena;
    if (zero_last) ena_eff[0] = 1'b1;
    eop_seg = '0;
    for (int k = 0; k < SEG_CNT; k++) if (ena_eff[k]) eop_seg = SEL_W'(k);
    for (int k = 0; k < SEG_CNT; k++) begin
      seg_d[k] = '0;
      if (ena_eff[k]) begin
        seg_d[k].data = map_data[k];
        seg_d[k].ena  = 1'b1;
        seg_d[k].sop  = (k == 0) && (state_q == ST_IDLE);
        if (s_axis.tlast && (eop_seg == SEL_W'(k))) begin
          seg_d[k].eop = 1'b1;
          seg_d[k].err = pkt_err_q | beat_err;
          seg_d[k].mty = map_mty[k];
        end
      end
    end
  end

  // ---- stage boundary: accepted beat -> LBUS output register ----
  // Output register: an accepted beat appears on LBUS the next cycle, otherwise idle zeros.
  always_ff @(posedge cmac_tx_clk or posedge cmac_rst) begin
    if (cmac_rst) begin
      for (int k = 0; k < SEG_CNT; k++) seg_q[k] <= '0;
    end else begin
      for (int k = 0; k < SEG_CNT; k++) seg_q[k] <= accept ? seg_d[k] : '0;
    end
  end

  // Control state: FSM, ready pipe, packet error latch, counters and sticky CMAC flags.
  always_ff @(posedge cmac_tx_clk or posedge cmac_rst) begin
    if (cmac_rst) begin
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b0;
      pkt_err_q <= 1'b0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= tx_rdyout;
      ovf_q   <= ovf_q | tx_ovfout;
      unf_q   <= unf_q | tx_unfout;
      if (accept) begin
        if (s_axis.tlast) begin
          pkt_err_q <= 1'b0;
          pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
          if (pkt_err_q | beat_err) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end else if (beat_err) begin
          pkt_err_q <= 1'b1;
        end
      end
    end
  end

  assign tx_datain0 = seg_q[0].data;  assign tx_datain1 = seg_q[1].data;
  assign tx_datain2 = seg_q[2].data;  assign tx_datain3 = seg_q[3].data;
  assign tx_enain0  = seg_q[0].ena;   assign tx_enain1  = seg_q[1].ena;
  assign tx_enain2  = seg_q[2].ena;   assign tx_enain3  = seg_q[3].ena;
  assign tx_sopin0  = seg_q[0].sop;   assign tx_sopin1  = seg_q[1].sop;
  assign tx_sopin2  = seg_q[2].sop;   assign tx_sopin3  = seg_q[3].sop;
  assign tx_eopin0  = seg_q[0].eop;   assign tx_eopin1  = seg_q[1].eop;
  assign tx_eopin2  = seg_q[2].eop;   assign tx_eopin3  = seg_q[3].eop;
  assign tx_errin0  = seg_q[0].err;   assign tx_errin1  = seg_q[1].err;
  assign tx_errin2  = seg_q[2].err;   assign tx_errin3  = seg_q[3].err;
  assign tx_mtyin0  = seg_q[0].mty;   assign tx_mtyin1  = seg_q[1].mty;
  assign tx_mtyin2  = seg_q[2].mty;   assign tx_mtyin3  = seg_q[3].mty;
  assign pkt_cnt    = pkt_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;
endmodule

// File: tb/tb_cmac_lbus_tx_adapter.sv
// Bench for cmac_lbus_tx_adapter: byte-level reference model plus directed packet scenarios.
module tb_cmac_lbus_tx_adapter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_enable = 1'b0, tx_rdyout = 1'b0, tx_ovfout = 1'b0, tx_unfout = 1'b0;
  logic [127:0] tx_datain0, tx_datain1, tx_datain2, tx_datain3;
  logic tx_enain0, tx_enain1, tx_enain2, tx_enain3;
  logic tx_sopin0, tx_sopin1, tx_sopin2, tx_sopin3;
  logic tx_eopin0, tx_eopin1, tx_eopin2, tx_eopin3;
  logic tx_errin0, tx_errin1, tx_errin2, tx_errin3;
  logic [3:0] tx_mtyin0, tx_mtyin1, tx_mtyin2, tx_mtyin3;
  logic [31:0] pkt_cnt, err_cnt;
  logic ovf_sticky, unf_sticky;

  cmac_lbus_tx_adapter_if axis();

  cmac_lbus_tx_adapter #(.SEG_CNT(4), .CNT_W(32)) dut (
    .cmac_tx_clk(clk), .cmac_rst(rst), .tx_enable(tx_enable), .s_axis(axis),
    .tx_rdyout(tx_rdyout), .tx_ovfout(tx_ovfout), .tx_unfout(tx_unfout),
    .tx_datain0(tx_datain0), .tx_datain1(tx_datain1), .tx_datain2(tx_datain2), .tx_datain3(tx_datain3),
    .tx_enain0(tx_enain0), .tx_enain1(tx_enain1), .tx_enain2(tx_enain2), .tx_enain3(tx_enain3),
    .tx_sopin0(tx_sopin0), .tx_sopin1(tx_sopin1), .tx_sopin2(tx_sopin2), .tx_sopin3(tx_sopin3),
    .tx_eopin0(tx_eopin0), .tx_eopin1(tx_eopin1), .tx_eopin2(tx_eopin2), .tx_eopin3(tx_eopin3),
    .tx_errin0(tx_errin0), .tx_errin1(tx_errin1), .tx_errin2(tx_errin2), .tx_errin3(tx_errin3),
    .tx_mtyin0(tx_mtyin0), .tx_mtyin1(tx_mtyin1), .tx_mtyin2(tx_mtyin2), .tx_mtyin3(tx_mtyin3),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // DUT outputs gathered per segment
  logic [127:0] d_data [4];
  logic [3:0]   d_mty  [4];
  assign d_data[0] = tx_datain0; assign d_data[1] = tx_datain1;
  assign d_data[2] = tx_datain2; assign d_data[3] = tx_datain3;
  assign d_mty[0]  = tx_mtyin0;  assign d_mty[1]  = tx_mtyin1;
  assign d_mty[2]  = tx_mtyin2;  assign d_mty[3]  = tx_mtyin3;
  wire [3:0] d_ena = {tx_enain3, tx_enain2, tx_enain1, tx_enain0};
  wire [3:0] d_sop = {tx_sopin3, tx_sopin2, tx_sopin1, tx_sopin0};
  wire [3:0] d_eop = {tx_eopin3, tx_eopin2, tx_eopin1, tx_eopin0};
  wire [3:0] d_err = {tx_errin3, tx_errin2, tx_errin1, tx_errin0};

  // Reference model state and expectations
  bit [127:0] e_data [4];
  bit [3:0]   e_mty  [4];
  bit [3:0]   e_ena, e_sop, e_eop, e_err;
  bit [31:0]  e_pkt, e_errc;
  bit         e_ovf, e_unf, m_rdy, m_inpkt, m_pkterr;

  task automatic clear_exp();
    for (int k = 0; k < 4; k++) begin e_data[k] = '0; e_mty[k] = '0; end
    e_ena = '0; e_sop = '0; e_eop = '0; e_err = '0;
  endtask

  // What one accepted beat must look like on LBUS, derived byte by byte.
  task automatic model_beat(input logic [511:0] d, input logic [63:0] keep, input logic last);
    int total, top, cnt [4];
    bit gap, noncontig, bad;
    total = 0; gap = 0; noncontig = 0; top = 0;
    for (int i = 0; i < 64; i++) begin
      if (keep[i]) begin total++; if (gap) noncontig = 1; end
      else gap = 1;
    end
    bad = noncontig || (!last && total != 64) || (last && total == 0);
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0;
      for (int j = 0; j < 16; j++) if (keep[16*k+j]) cnt[k]++;
      e_ena[k] = (cnt[k] > 0) || (last && total == 0 && k == 0);
      if (e_ena[k]) begin
        top = k;
        for (int j = 0; j < 16; j++) e_data[k][127-8*j -: 8] = d[8*(16*k+j) +: 8];
      end
    end
    if (!m_inpkt && e_ena[0]) e_sop[0] = 1'b1;
    if (last) begin
      e_eop[top] = 1'b1;
      e_mty[top] = (cnt[top] == 0) ? 4'd15 : 4'(16 - cnt[top]);
      e_err[top] = m_pkterr || bad;
      e_pkt = e_pkt + 1;
      if (m_pkterr || bad) e_errc = e_errc + 1;
      m_pkterr = 0;
      m_inpkt = 0;
    end else begin
      if (bad) m_pkterr = 1;
      m_inpkt = 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rdy = 0; m_inpkt = 0; m_pkterr = 0; e_pkt = 0; e_errc = 0; e_ovf = 0; e_unf = 0;
      clear_exp();
    end else begin
      bit tr;
      tr = m_rdy && (m_inpkt || tx_enable);
      clear_exp();
      if (axis.tvalid && tr) model_beat(axis.tdata, axis.tkeep, axis.tlast);
      m_rdy = tx_rdyout;
      e_ovf = e_ovf | tx_ovfout;
      e_unf = e_unf | tx_unfout;
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tready", axis.tready, m_rdy && (m_inpkt || tx_enable));
      chk("ena", d_ena, e_ena);
      chk("sop", d_sop, e_sop);
      chk("eop", d_eop, e_eop);
      chk("err", d_err, e_err);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("data%0d", k), d_data[k], e_data[k]);
        chk($sformatf("mty%0d", k), d_mty[k], e_mty[k]);
      end
      chk("pkt_cnt", pkt_cnt, e_pkt);
      chk("err_cnt", err_cnt, e_errc);
      chk("ovf_sticky", ovf_sticky, e_ovf);
      chk("unf_sticky", unf_sticky, e_unf);
    end
  end

  function automatic logic [511:0] ramp(input logic [7:0] base);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[8*i +: 8] = base + 8'(i);
    return d;
  endfunction

  // Present a beat and hold it until accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    bit ok;
    int n;
    axis.tdata = d; axis.tkeep = k; axis.tlast = l; axis.tvalid = 1'b1;
    ok = 0; n = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = (axis.tready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: beat not accepted in %0d cycles, required acceptance", n);
    end
    axis.tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    axis.tdata = '0; axis.tkeep = '0; axis.tlast = 1'b0; axis.tvalid = 1'b0;
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", axis.tready, 1'b0);
    chk("rst_ena", d_ena, 4'b0000);
    chk("rst_pkt_cnt", pkt_cnt, 32'd0);
    rst = 1'b0;
    tx_rdyout = 1'b1; tx_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 64-byte single-beat packet
    send_beat(ramp(8'h01), '1, 1'b1);
    chk("b64_ena", d_ena, 4'b1111);
    chk("b64_sop0", tx_sopin0, 1'b1);
    chk("b64_eop3", tx_eopin3, 1'b1);
    chk("b64_mty3", tx_mtyin3, 4'd0);
    chk("b64_pkt_cnt", pkt_cnt, 32'd1);
    chk("b64_d0_top", tx_datain0[127:120], 8'h01);
    chk("b64_d3_low", tx_datain3[7:0], 8'h40);

    // 65-byte packet: full beat then a single byte
    send_beat(ramp(8'h41), '1, 1'b0);
    send_beat({504'd0, 8'hA5}, 64'h1, 1'b1);
    chk("b65_ena", d_ena, 4'b0001);
    chk("b65_eop0", tx_eopin0, 1'b1);
    chk("b65_mty0", tx_mtyin0, 4'd15);
    chk("b65_sop0", tx_sopin0, 1'b0);
    chk("b65_byte64", tx_datain0[127:120], 8'hA5);
    chk("b65_pkt_cnt", pkt_cnt, 32'd2);

    // CMAC ready dropping in the middle of a 3-beat packet
    fork
      begin
        send_beat(ramp(8'h10), '1, 1'b0);
        send_beat(ramp(8'h50), '1, 1'b0);
        send_beat(ramp(8'h90), 64'h00FF_FFFF_FFFF, 1'b1);
      end
      begin
        @(posedge clk); #1 tx_rdyout = 1'b0;
        @(posedge clk); #1;
        chk("bp_tready_lo", axis.tready, 1'b0);
        repeat (2) @(posedge clk);
        #1 tx_rdyout = 1'b1;
      end
    join
    chk("bp_pkt_cnt", pkt_cnt, 32'd3);
    chk("bp_mty2", tx_mtyin2, 4'd8);

    // tx_enable low in IDLE blocks a new packet
    tx_enable = 1'b0;
    axis.tdata = ramp(8'h20); axis.tkeep = '1; axis.tlast = 1'b1; axis.tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("en_lo_tready", axis.tready, 1'b0);
    tx_enable = 1'b1;
    send_beat(ramp(8'h20), '1, 1'b1);
    // tx_enable dropped mid-packet: packet still completes
    send_beat(ramp(8'h30), '1, 1'b0);
    tx_enable = 1'b0;
    send_beat(ramp(8'h70), '1, 1'b1);
    chk("en_mid_eop3", tx_eopin3, 1'b1);
    axis.tdata = ramp(8'h80); axis.tkeep = '1; axis.tlast = 1'b1; axis.tvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("en_next_blocked", axis.tready, 1'b0);
    tx_enable = 1'b1;
    send_beat(ramp(8'h80), '1, 1'b1);

    // Short non-last beat marks the packet bad
    send_beat(ramp(8'hC0), 64'h0000_FFFF, 1'b0);
    send_beat(ramp(8'h00), '1, 1'b1);
    chk("mal_err3", tx_errin3, 1'b1);
    chk("mal_err_cnt", err_cnt, 32'd1);

    // Non-contiguous last beat
    send_beat(ramp(8'h11), 64'hFF0F, 1'b1);
    chk("nc_err0", tx_errin0, 1'b1);
    chk("nc_mty0", tx_mtyin0, 4'd4);
    chk("nc_err_cnt", err_cnt, 32'd2);

    // Zero-keep last beat from IDLE
    send_beat('0, 64'h0, 1'b1);
    chk("zk_ctrl", {tx_enain0, tx_sopin0, tx_eopin0, tx_errin0}, 4'b1111);
    chk("zk_mty0", tx_mtyin0, 4'd15);
    chk("zk_err_cnt", err_cnt, 32'd3);

    // Asynchronous reset mid-packet
    send_beat(ramp(8'h55), '1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_ena", d_ena, 4'b0000);
    chk("arst_tready", axis.tready, 1'b0);
    chk("arst_pkt_cnt", pkt_cnt, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tx_ovfout = 1'b1;
    @(posedge clk);
    #1 tx_ovfout = 1'b0;
    @(posedge clk);
    #1;
    chk("ovf_sticky_set", ovf_sticky, 1'b1);
    chk("unf_sticky_clr", unf_sticky, 1'b0);
    send_beat(ramp(8'h66), '1, 1'b1);
    chk("arst_next_sop0", tx_sopin0, 1'b1);
    chk("arst_next_pkt_cnt", pkt_cnt, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
